// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio
//  Description : Data-side memory for a single-cycle CPU. Byte-writable RAM
//                with same-cycle read, plus an MMIO window containing a TX
//                byte FIFO (valid/ready drain), a status register and a
//                free-running cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int c_AW = $clog2(MEM_WORDS);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    // Word indices (byte address >> 2) of the MMIO registers
    localparam logic [29:0]     c_TXDATA_WORD = 30'h2000_0000;
    localparam logic [29:0]     c_STATUS_WORD = 30'h2000_0001;
    localparam logic [29:0]     c_CYCLE_WORD  = 30'h2000_0002;
    localparam logic [c_CW-1:0] c_FULL_COUNT  = c_CW'(FIFO_DEPTH);

    logic [31:0]     r_mem [MEM_WORDS];
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic [31:0]     r_cycle;

    logic [c_AW-1:0] w_ram_idx;
    logic            w_ram_sel;
    logic            w_txd_sel;
    logic            w_stat_sel;
    logic            w_cyc_sel;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_push_ok;
    logic [7:0]      w_count8;
    logic            w_unused;

    // Byte offset within a word plays no part in decoding
    assign w_unused   = &{1'b0, daddr[1:0]};

    assign w_ram_idx  = daddr[c_AW+1:2];
    assign w_ram_sel  = (daddr[31:c_AW+2] == '0);
    assign w_txd_sel  = (daddr[31:2] == c_TXDATA_WORD);
    assign w_stat_sel = (daddr[31:2] == c_STATUS_WORD);
    assign w_cyc_sel  = (daddr[31:2] == c_CYCLE_WORD);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_pop      = tx_valid & tx_ready;
    assign w_push     = ~reset & w_txd_sel & dwe[0];
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_count8   = 8'(r_count);

    assign tx_valid   = ~w_empty;
    assign tx_data    = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && w_ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
        end
    end

    // FIFO storage write at the tail
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= dwdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push_ok) - c_CW'(w_pop);
            // A new overflow takes priority over a simultaneous clear
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_stat_sel && dwe[0] && dwdata[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Free-running cycle counter, cleared by any write to its register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_cyc_sel && (dwe != 4'b0000)) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Same-cycle read mux over the address map
    always_comb begin
        drdata = 32'h0;
        if (w_ram_sel) begin
            drdata = r_mem[w_ram_idx];
        end else if (w_stat_sel) begin
            drdata = {16'h0, w_count8, 5'b0, r_ovf, w_empty, w_full};
        end else if (w_cyc_sel) begin
            drdata = r_cycle;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_mmio
//  Description : Self-checking bench for dmem_mmio. A reference model built
//                from an array, a byte queue and plain counters is advanced
//                once per clock and compared against the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio;

    localparam int MEM   = 1024;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_TX   = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_CYC  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [3:0]  dwe = '0;
    logic [31:0] drdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    dmem_mmio #(.MEM_WORDS(MEM), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [MEM];
    logic [7:0]  m_q [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cyc = '0;
    logic [7:0]  got [$];

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < 32'(4 * MEM)) return m_mem[int'(a >> 2)];
        if ((a >> 2) == (A_STAT >> 2))
            return {16'h0, 8'(m_q.size()), 5'b0, m_ovf,
                    1'(m_q.size() == 0), 1'(m_q.size() == DEPTH)};
        if ((a >> 2) == (A_CYC >> 2)) return m_cyc;
        return 32'h0;
    endfunction

    // Advance the model by one clock with the given inputs
    task automatic m_step(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] we, input logic rdy);
        bit pop;
        bit set_ovf;
        pop = (m_q.size() != 0) && rdy;
        set_ovf = 1'b0;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cyc = '0;
            return;
        end
        if ((a >> 2) == (A_CYC >> 2) && we != 4'b0) m_cyc = '0;
        else m_cyc = m_cyc + 32'd1;
        if (a < 32'(4 * MEM)) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) m_mem[int'(a >> 2)][8*i +: 8] = wd[8*i +: 8];
        end
        if (pop) begin
            got.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if ((a >> 2) == (A_TX >> 2) && we[0]) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd[7:0]);
            else set_ovf = 1'b1;
        end
        if (set_ovf) m_ovf = 1'b1;
        else if ((a >> 2) == (A_STAT >> 2) && we[0] && wd[2]) m_ovf = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational outputs, step model
    task automatic cyc(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic rdy, input string tag);
        reset = rst; daddr = a; dwdata = wd; dwe = we; tx_ready = rdy;
        #1;
        if (chk_en) begin
            chk({tag, "_rd"}, drdata, m_read(a));
            chk({tag, "_vld"}, 32'(tx_valid), 32'(m_q.size() != 0));
            chk({tag, "_dat"}, 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        end
        @(posedge clk);
        m_step(rst, a, wd, we, rdy);
        @(negedge clk);
    endtask

    // Look at a read value without writing; must be followed by cyc before posedge
    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        daddr = a; dwe = 4'b0; tx_ready = 1'b0;
        #1;
        chk(tag, drdata, exp);
    endtask

    logic [7:0] exp_order [8];
    logic [31:0] ra, rwd;
    logic [3:0]  rwe;

    initial begin
        exp_order = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h55};
        @(negedge clk);
        cyc(1'b1, A_STAT, 32'h0, 4'h0, 1'b0, "rst0");
        chk_en = 1'b1;
        cyc(1'b1, A_STAT, 32'h0, 4'h0, 1'b0, "rst1");
        peek(A_STAT, 32'h0000_0002, "rst_status");
        peek(A_CYC, 32'h0, "rst_cycle");
        chk("rst_txvalid", 32'(tx_valid), 32'h0);

        // Give every RAM word a known value
        chk_en = 1'b0;
        for (int w = 0; w < MEM; w++) cyc(1'b0, 32'(w * 4), $urandom, 4'hF, 1'b0, "init");
        chk_en = 1'b1;

        // T1: byte-lane merge
        cyc(1'b0, 32'h10, 32'hA5A5_1234, 4'hF, 1'b0, "t1_w");
        cyc(1'b0, 32'h10, 32'h00CC_0000, 4'b0100, 1'b0, "t1_b");
        peek(32'h10, 32'hA5CC_1234, "t1_merge");
        peek(32'h13, 32'hA5CC_1234, "t1_lowbits");

        // RAM boundary and unmapped reads/writes
        cyc(1'b0, 32'(4 * MEM), 32'hDEAD_BEEF, 4'hF, 1'b0, "oob_w");
        peek(32'(4 * MEM), 32'h0, "oob_rd");
        peek(32'h0, m_mem[0], "oob_noalias");
        cyc(1'b0, 32'(4 * MEM - 4), 32'h0BAD_F00D, 4'hF, 1'b0, "top_w");
        peek(32'(4 * MEM - 4), 32'h0BAD_F00D, "top_rd");
        peek(32'h8000_000C, 32'h0, "unmapped");
        peek(A_TX, 32'h0, "txdata_rd");

        // T2: fill, overflow, W1C
        for (int b = 0; b < 8; b++) cyc(1'b0, A_TX, 32'(8'h41 + b), 4'h1, 1'b0, "t2_push");
        peek(A_STAT, 32'h0000_0801, "t2_full");
        cyc(1'b0, A_TX, 32'h49, 4'h1, 1'b0, "t2_ovf");
        peek(A_STAT, 32'h0000_0805, "t2_ovfset");
        cyc(1'b0, A_STAT, 32'h4, 4'h1, 1'b0, "t2_w1c");
        peek(A_STAT, 32'h0000_0801, "t2_ovfclr");

        // T3: push into full FIFO with simultaneous pop
        cyc(1'b0, A_TX, 32'h55, 4'h1, 1'b1, "t3_pp");
        peek(A_STAT, 32'h0000_0801, "t3_status");

        // T4: drain with tx_ready toggling
        got.delete();
        for (int i = 0; i < 40 && m_q.size() != 0; i++)
            cyc(1'b0, A_STAT, 32'h0, 4'h0, 1'(i % 2 == 0), "t4_drain");
        chk("t4_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("t4_order", (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));
        peek(A_STAT, 32'h0000_0002, "t4_empty");
        chk("t4_txvalid", 32'(tx_valid), 32'h0);
        chk("t4_txdata", 32'(tx_data), 32'h0);

        // T5: cycle counter
        cyc(1'b1, A_CYC, 32'h0, 4'h0, 1'b0, "t5_rst");
        for (int i = 0; i < 100; i++) cyc(1'b0, A_STAT, 32'h0, 4'h0, 1'b0, "t5_run");
        peek(A_CYC, 32'd100, "t5_100");
        cyc(1'b0, A_CYC, 32'h0, 4'h2, 1'b0, "t5_clr");
        peek(A_CYC, 32'd0, "t5_zero");
        cyc(1'b0, A_CYC, 32'h0, 4'h0, 1'b0, "t5_inc");
        peek(A_CYC, 32'd1, "t5_one");
        dut.r_cycle = 32'hFFFF_FFFE;
        m_cyc = 32'hFFFF_FFFE;
        cyc(1'b0, A_CYC, 32'h0, 4'h0, 1'b0, "t5_pre");
        peek(A_CYC, 32'hFFFF_FFFF, "t5_max");
        cyc(1'b0, A_CYC, 32'h0, 4'h0, 1'b0, "t5_wrap");
        peek(A_CYC, 32'h0, "t5_wrapped");

        // T6: reset mid-use discards FIFO, keeps RAM, blocks writes
        for (int b = 0; b < 3; b++) cyc(1'b0, A_TX, 32'(8'h61 + b), 4'h1, 1'b0, "t6_push");
        cyc(1'b0, 32'h14, 32'h1234_5678, 4'hF, 1'b0, "t6_ram");
        cyc(1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b1, "t6_rst");
        chk("t6_txvalid", 32'(tx_valid), 32'h0);
        peek(A_STAT, 32'h0000_0002, "t6_status");
        peek(32'h14, 32'h1234_5678, "t6_ram_kept");
        cyc(1'b1, A_TX, 32'h77, 4'h1, 1'b0, "t6_rstpush");
        peek(A_STAT, 32'h0000_0002, "t6_nopush");

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    ra = 32'($urandom_range(0, MEM - 1) * 4 + $urandom_range(0, 3));
                2:       ra = A_TX + 32'($urandom_range(0, 3));
                3:       ra = A_STAT + 32'($urandom_range(0, 3));
                4:       ra = A_CYC;
                default: ra = ($urandom_range(0, 1) != 0) ? 32'(4 * MEM) + 32'($urandom_range(0, 255))
                                                           : 32'h8000_000C;
            endcase
            rwd = $urandom;
            rwe = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            cyc(1'($urandom_range(0, 49) == 0), ra, rwd, rwe, 1'($urandom_range(0, 2) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
